// File: rtl/csr_register_bridge.sv
// Purpose: AXI4-Lite slave that turns each single-beat transaction into one CSR_FF access.
// Latency: write strobe T+1 and bvalid T+2, read strobe T+1 and rvalid T+2+READ_LATENCY, decode errors respond at T+1.
// Backpressure: only one transaction is outstanding; no ready is raised until the pending response is accepted.
module csr_register_bridge #(
  parameter int CSR_DATA_WIDTH     = 32,  // AXI-Lite data path is 32 bits wide, so this must stay 32
  parameter int CSR_ADDRESS_WIDTH  = 8,
  parameter int AXIL_ADDRESS_WIDTH = 12,  // must be at least CSR_ADDRESS_WIDTH+2
  parameter int READ_LATENCY       = 1    // 0..7
) (
  input  logic                          clock,
  input  logic                          reset_n,
  // write address / data / response
  input  logic [AXIL_ADDRESS_WIDTH-1:0] s_axil_awaddr,
  input  logic                          s_axil_awvalid,
  output logic                          s_axil_awready,
  input  logic [CSR_DATA_WIDTH-1:0]     s_axil_wdata,
  input  logic [3:0]                    s_axil_wstrb,
  input  logic                          s_axil_wvalid,
  output logic                          s_axil_wready,
  output logic [1:0]                    s_axil_bresp,
  output logic                          s_axil_bvalid,
  input  logic                          s_axil_bready,
  // read address / data
  input  logic [AXIL_ADDRESS_WIDTH-1:0] s_axil_araddr,
  input  logic                          s_axil_arvalid,
  output logic                          s_axil_arready,
  output logic [CSR_DATA_WIDTH-1:0]     s_axil_rdata,
  output logic [1:0]                    s_axil_rresp,
  output logic                          s_axil_rvalid,
  input  logic                          s_axil_rready,
  // application register port
  output logic                          CSR_FF_valid,
  output logic                          CSR_FF_write_enable,
  output logic [CSR_ADDRESS_WIDTH-1:0]  CSR_FF_address,
  output logic [CSR_DATA_WIDTH-1:0]     CSR_FF_write_data,
  input  logic [CSR_DATA_WIDTH-1:0]     CSR_FF_read_data
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam int         ADDR_TOP    = CSR_ADDRESS_WIDTH + 2;
  // RD_WAIT lasts READ_LATENCY cycles; the counter counts down to the capture cycle
  localparam logic [2:0] CNT_LOAD    = (READ_LATENCY > 0) ? 3'(READ_LATENCY - 1) : 3'd0;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR_ISSUE = 3'd1,
    WR_RESP  = 3'd2,
    RD_ISSUE = 3'd3,
    RD_WAIT  = 3'd4,
    RD_RESP  = 3'd5
  } state_t;

  state_t                         state_q;
  logic                           wr_rdy_q;     // drives awready and wready together
  logic                           rd_rdy_q;
  logic                           bvalid_q;
  logic [1:0]                     bresp_q;
  logic                           rvalid_q;
  logic [1:0]                     rresp_q;
  logic [CSR_DATA_WIDTH-1:0]      rdata_q;
  logic                           csr_vld_q;
  logic                           csr_we_q;
  logic [CSR_ADDRESS_WIDTH-1:0]   csr_addr_q;
  logic [CSR_DATA_WIDTH-1:0]      csr_wdat_q;
  logic                           prefer_wr_q;  // arbitration pointer: 1 = write wins a tie
  logic [2:0]                     cnt_q;

  logic wr_req;
  logic rd_req;
  logic pick_wr;
  logic wr_err;
  logic rd_err;

  // Request decode: a write needs both AW and W; ties go to the type not served last.
  // Any address bit above the CSR word range, or a partial strobe on writes, is rejected.
  always_comb begin
    wr_req  = s_axil_awvalid && s_axil_wvalid;
    rd_req  = s_axil_arvalid;
    pick_wr = wr_req && (!rd_req || prefer_wr_q);
    wr_err  = ((s_axil_awaddr >> ADDR_TOP) != '0) || (s_axil_wstrb != 4'hF);
    rd_err  = ((s_axil_araddr >> ADDR_TOP) != '0);
  end

  // Transaction FSM: all outputs are registered; CSR strobe defaults low so it only lasts one cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      wr_rdy_q    <= 1'b0;
      rd_rdy_q    <= 1'b0;
      bvalid_q    <= 1'b0;
      bresp_q     <= RESP_OKAY;
      rvalid_q    <= 1'b0;
      rresp_q     <= RESP_OKAY;
      rdata_q     <= '0;
      csr_vld_q   <= 1'b0;
      csr_we_q    <= 1'b0;
      csr_addr_q  <= '0;
      csr_wdat_q  <= '0;
      prefer_wr_q <= 1'b1;
      cnt_q       <= 3'd0;
    end else begin
      csr_vld_q <= 1'b0;
      csr_we_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (wr_rdy_q) begin
            // handshake cycle for a write
            wr_rdy_q <= 1'b0;
            if (wr_req) begin
              prefer_wr_q <= 1'b0;
              if (wr_err) begin
                bresp_q  <= RESP_SLVERR;
                bvalid_q <= 1'b1;
                state_q  <= WR_RESP;
              end else begin
                bresp_q    <= RESP_OKAY;
                csr_addr_q <= s_axil_awaddr[CSR_ADDRESS_WIDTH+1:2];
                csr_wdat_q <= s_axil_wdata;
                csr_vld_q  <= 1'b1;
                csr_we_q   <= 1'b1;
                state_q    <= WR_ISSUE;
              end
            end
          end else if (rd_rdy_q) begin
            // handshake cycle for a read
            rd_rdy_q <= 1'b0;
            if (rd_req) begin
              prefer_wr_q <= 1'b1;
              if (rd_err) begin
                rresp_q  <= RESP_SLVERR;
                rdata_q  <= '0;
                rvalid_q <= 1'b1;
                state_q  <= RD_RESP;
              end else begin
                rresp_q    <= RESP_OKAY;
                csr_addr_q <= s_axil_araddr[CSR_ADDRESS_WIDTH+1:2];
                csr_vld_q  <= 1'b1;
                state_q    <= RD_ISSUE;
              end
            end
          end else if (pick_wr) begin
            wr_rdy_q <= 1'b1;
          end else if (rd_req) begin
            rd_rdy_q <= 1'b1;
          end
        end
        WR_ISSUE: begin
          bvalid_q <= 1'b1;
          state_q  <= WR_RESP;
        end
        WR_RESP: begin
          if (s_axil_bready) begin
            bvalid_q <= 1'b0;
            state_q  <= IDLE;
          end
        end
        RD_ISSUE: begin
          if (READ_LATENCY == 0) begin
            rdata_q  <= CSR_FF_read_data;
            rvalid_q <= 1'b1;
            state_q  <= RD_RESP;
          end else begin
            cnt_q   <= CNT_LOAD;
            state_q <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (cnt_q == 3'd0) begin
            rdata_q  <= CSR_FF_read_data;
            rvalid_q <= 1'b1;
            state_q  <= RD_RESP;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        RD_RESP: begin
          if (s_axil_rready) begin
            rvalid_q <= 1'b0;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign s_axil_awready      = wr_rdy_q;
  assign s_axil_wready       = wr_rdy_q;
  assign s_axil_arready      = rd_rdy_q;
  assign s_axil_bvalid       = bvalid_q;
  assign s_axil_bresp        = bresp_q;
  assign s_axil_rvalid       = rvalid_q;
  assign s_axil_rresp        = rresp_q;
  assign s_axil_rdata        = rdata_q;
  assign CSR_FF_valid        = csr_vld_q;
  assign CSR_FF_write_enable = csr_we_q;
  assign CSR_FF_address      = csr_addr_q;
  assign CSR_FF_write_data   = csr_wdat_q;

endmodule

// File: tb/tb_csr_register_bridge.sv
// Purpose: self-checking bench for csr_register_bridge at READ_LATENCY 1, 0 and 3 against a transaction-level model.
// Latency: expected response cycle is derived from the handshake cycle and the error/latency rules.
// Backpressure: random bready/rready stalls, plus a directed stall with a competing read held off.
`timescale 1ns/1ps
module tb_csr_register_bridge;

  localparam int N = 3;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  int last_resp_hs = -1;

  logic        rst_n    [N];
  logic [11:0] awaddr   [N];
  logic        awvalid  [N];
  logic        awready  [N];
  logic [31:0] wdata    [N];
  logic [3:0]  wstrb    [N];
  logic        wvalid   [N];
  logic        wready   [N];
  logic [1:0]  bresp    [N];
  logic        bvalid   [N];
  logic        bready   [N];
  logic [11:0] araddr   [N];
  logic        arvalid  [N];
  logic        arready  [N];
  logic [31:0] rdata    [N];
  logic [1:0]  rresp    [N];
  logic        rvalid   [N];
  logic        rready   [N];
  logic        csr_vld  [N];
  logic        csr_we   [N];
  logic [7:0]  csr_addr [N];
  logic [31:0] csr_wdat [N];
  logic [31:0] csr_rdat [N];

  // last observed CSR strobe per instance
  int          strobe_cnt  [N];
  int          strobe_cyc  [N];
  logic [7:0]  strobe_addr [N];
  logic        strobe_we   [N];
  logic [31:0] strobe_dat  [N];

  // reference model: expected CSR contents
  logic [31:0] ref_mem  [N][256];
  bit          ref_mark [N][256];

  function automatic int rl_of(int k);
    return (k == 0) ? 1 : (k == 1) ? 0 : 3;
  endfunction

  // power-on contents of the application registers
  function automatic logic [31:0] init_val(int k, logic [7:0] a);
    if (a == 8'd4) return 32'h12345678;
    return {8'(k + 1), a, ~a, a ^ 8'hA5};
  endfunction

  function automatic logic [31:0] ref_read(int k, logic [7:0] w);
    return ref_mark[k][w] ? ref_mem[k][w] : init_val(k, w);
  endfunction

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int RL = (g == 0) ? 1 : (g == 1) ? 0 : 3;
    logic [31:0] mem     [256];
    bit          wr_mark [256];
    logic [7:0]  rd_addr;
    int          age;
    bit          pend;

    csr_register_bridge #(.READ_LATENCY(RL)) u_dut (
      .clock               (clock),
      .reset_n             (rst_n[g]),
      .s_axil_awaddr       (awaddr[g]),
      .s_axil_awvalid      (awvalid[g]),
      .s_axil_awready      (awready[g]),
      .s_axil_wdata        (wdata[g]),
      .s_axil_wstrb        (wstrb[g]),
      .s_axil_wvalid       (wvalid[g]),
      .s_axil_wready       (wready[g]),
      .s_axil_bresp        (bresp[g]),
      .s_axil_bvalid       (bvalid[g]),
      .s_axil_bready       (bready[g]),
      .s_axil_araddr       (araddr[g]),
      .s_axil_arvalid      (arvalid[g]),
      .s_axil_arready      (arready[g]),
      .s_axil_rdata        (rdata[g]),
      .s_axil_rresp        (rresp[g]),
      .s_axil_rvalid       (rvalid[g]),
      .s_axil_rready       (rready[g]),
      .CSR_FF_valid        (csr_vld[g]),
      .CSR_FF_write_enable (csr_we[g]),
      .CSR_FF_address      (csr_addr[g]),
      .CSR_FF_write_data   (csr_wdat[g]),
      .CSR_FF_read_data    (csr_rdat[g])
    );

    // application register file: writes land on the strobe edge, read data is valid only RL cycles after the strobe
    always @(posedge clock) begin
      if (csr_vld[g] && csr_we[g]) begin
        mem[csr_addr[g]]     <= csr_wdat[g];
        wr_mark[csr_addr[g]] <= 1'b1;
      end
      if (csr_vld[g] && !csr_we[g]) begin
        pend    <= 1'b1;
        age     <= 0;
        rd_addr <= csr_addr[g];
      end else if (pend && age < 1000) begin
        age <= age + 1;
      end
    end

    always_comb begin
      csr_rdat[g] = 32'hBADC0DE5;
      if (RL == 0 && csr_vld[g] && !csr_we[g])
        csr_rdat[g] = wr_mark[csr_addr[g]] ? mem[csr_addr[g]] : init_val(g, csr_addr[g]);
      else if (pend && age + 1 == RL)
        csr_rdat[g] = wr_mark[rd_addr] ? mem[rd_addr] : init_val(g, rd_addr);
    end

    // strobe monitor
    always @(negedge clock) begin
      if (csr_vld[g]) begin
        strobe_cnt[g]  <= strobe_cnt[g] + 1;
        strobe_cyc[g]  <= cyc;
        strobe_addr[g] <= csr_addr[g];
        strobe_we[g]   <= csr_we[g];
        strobe_dat[g]  <= csr_wdat[g];
      end else if (csr_we[g]) begin
        check("we_without_valid", 32'(csr_we[g]), 32'd0);
      end
    end
  end

  task automatic write_txn(int k, logic [11:0] a, logic [31:0] d, logic [3:0] s, int dly, bit ar_in_stall);
    bit err;
    int t, n, s0;
    err = (a[11:10] != 2'b00) || (s != 4'hF);
    s0  = strobe_cnt[k];
    awaddr[k] = a; wdata[k] = d; wstrb[k] = s;
    awvalid[k] = 1'b1; wvalid[k] = 1'b1; bready[k] = (dly == 0);
    n = 0;
    while (!(awready[k] && wready[k]) && n < 64) begin @(negedge clock); n++; end
    if (n >= 64) begin
      check("wr_accept_timeout", 32'd0, 32'd1);
      awvalid[k] = 1'b0; wvalid[k] = 1'b0;
      return;
    end
    t = cyc;
    check("wr_accept_after_prev_resp", 32'(t > last_resp_hs), 32'd1);
    @(negedge clock);
    awvalid[k] = 1'b0; wvalid[k] = 1'b0;
    n = 0;
    while (!bvalid[k] && n < 64) begin @(negedge clock); n++; end
    if (n >= 64) begin check("wr_bvalid_timeout", 32'd0, 32'd1); return; end
    check("wr_b_latency", 32'(cyc - t), err ? 32'd1 : 32'd2);
    check("wr_bresp", 32'(bresp[k]), err ? 32'd2 : 32'd0);
    if (ar_in_stall) arvalid[k] = 1'b1;
    for (int i = 0; i < dly; i++) begin
      @(negedge clock);
      check("wr_stall_bvalid", 32'(bvalid[k]), 32'd1);
      check("wr_stall_bresp", 32'(bresp[k]), err ? 32'd2 : 32'd0);
      check("wr_stall_no_ready", {29'd0, awready[k], wready[k], arready[k]}, 32'd0);
    end
    bready[k] = 1'b1;
    last_resp_hs = cyc;
    @(negedge clock);
    check("wr_bvalid_drop", 32'(bvalid[k]), 32'd0);
    check("wr_strobe_count", 32'(strobe_cnt[k] - s0), err ? 32'd0 : 32'd1);
    if (!err) begin
      check("wr_strobe_cycle", 32'(strobe_cyc[k]), 32'(t + 1));
      check("wr_strobe_addr", 32'(strobe_addr[k]), 32'(a[9:2]));
      check("wr_strobe_we", 32'(strobe_we[k]), 32'd1);
      check("wr_strobe_data", strobe_dat[k], d);
      ref_mem[k][a[9:2]]  = d;
      ref_mark[k][a[9:2]] = 1'b1;
    end
  endtask

  task automatic read_txn(int k, logic [11:0] a, int dly);
    bit err;
    int t, n, s0;
    logic [31:0] exp_d;
    err   = (a[11:10] != 2'b00);
    exp_d = err ? 32'd0 : ref_read(k, a[9:2]);
    s0    = strobe_cnt[k];
    araddr[k] = a; arvalid[k] = 1'b1; rready[k] = (dly == 0);
    n = 0;
    while (!arready[k] && n < 64) begin @(negedge clock); n++; end
    if (n >= 64) begin
      check("rd_accept_timeout", 32'd0, 32'd1);
      arvalid[k] = 1'b0;
      return;
    end
    t = cyc;
    check("rd_accept_after_prev_resp", 32'(t > last_resp_hs), 32'd1);
    @(negedge clock);
    arvalid[k] = 1'b0;
    n = 0;
    while (!rvalid[k] && n < 64) begin @(negedge clock); n++; end
    if (n >= 64) begin check("rd_rvalid_timeout", 32'd0, 32'd1); return; end
    check("rd_r_latency", 32'(cyc - t), err ? 32'd1 : 32'(2 + rl_of(k)));
    check("rd_rresp", 32'(rresp[k]), err ? 32'd2 : 32'd0);
    check("rd_rdata", rdata[k], exp_d);
    for (int i = 0; i < dly; i++) begin
      @(negedge clock);
      check("rd_stall_rvalid", 32'(rvalid[k]), 32'd1);
      check("rd_stall_rdata", rdata[k], exp_d);
      check("rd_stall_no_ready", {29'd0, awready[k], wready[k], arready[k]}, 32'd0);
    end
    rready[k] = 1'b1;
    last_resp_hs = cyc;
    @(negedge clock);
    check("rd_rvalid_drop", 32'(rvalid[k]), 32'd0);
    check("rd_strobe_count", 32'(strobe_cnt[k] - s0), err ? 32'd0 : 32'd1);
    if (!err) begin
      check("rd_strobe_cycle", 32'(strobe_cyc[k]), 32'(t + 1));
      check("rd_strobe_addr", 32'(strobe_addr[k]), 32'(a[9:2]));
      check("rd_strobe_we", 32'(strobe_we[k]), 32'd0);
    end
  endtask

  // all three requests held from reset: order must be W,R,W,R with one strobe each
  task automatic arb_test(int k);
    bit got [4];
    int nh, n, s0;
    logic [31:0] d;
    d  = $urandom;
    s0 = strobe_cnt[k];
    awaddr[k] = 12'h020; wdata[k] = d; wstrb[k] = 4'hF; araddr[k] = 12'h024;
    bready[k] = 1'b1; rready[k] = 1'b1;
    awvalid[k] = 1'b1; wvalid[k] = 1'b1; arvalid[k] = 1'b1;
    nh = 0; n = 0;
    while (nh < 4 && n < 100) begin
      if (awready[k] && wready[k]) begin got[nh] = 1'b1; nh++; end
      else if (arready[k]) begin got[nh] = 1'b0; nh++; end
      @(negedge clock);
      n++;
    end
    awvalid[k] = 1'b0; wvalid[k] = 1'b0; arvalid[k] = 1'b0;
    repeat (12) @(negedge clock);
    last_resp_hs = cyc;
    check("arb_handshakes", 32'(nh), 32'd4);
    for (int i = 0; i < 4; i++) check($sformatf("arb_order_%0d", i), 32'(got[i]), 32'(i % 2 == 0));
    check("arb_strobes", 32'(strobe_cnt[k] - s0), 32'(nh));
    check("arb_idle_after", {30'd0, bvalid[k], rvalid[k]}, 32'd0);
    ref_mem[k][8]  = d;
    ref_mark[k][8] = 1'b1;
  endtask

  task automatic reset_mid_test(int k);
    int n;
    araddr[k] = 12'h010; arvalid[k] = 1'b1; rready[k] = 1'b1;
    n = 0;
    while (!arready[k] && n < 64) begin @(negedge clock); n++; end
    @(negedge clock);
    arvalid[k] = 1'b0;
    check("rst_rd_strobe_seen", 32'(csr_vld[k]), 32'd1);
    @(negedge clock);
    rst_n[k] = 1'b0;
    #1;
    check("rst_rd_ctrl", {25'd0, csr_vld[k], csr_we[k], arready[k], awready[k], wready[k], rvalid[k], bvalid[k]}, 32'd0);
    check("rst_rd_addr", 32'(csr_addr[k]), 32'd0);
    check("rst_rd_rdata", rdata[k], 32'd0);
    check("rst_rd_resp", {28'd0, rresp[k], bresp[k]}, 32'd0);
    repeat (2) @(negedge clock);
    rst_n[k] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      check("rst_no_response", 32'(rvalid[k]), 32'd0);
    end
    // reset landing inside a write strobe must kill the strobe at once
    awaddr[k] = 12'h03C; wdata[k] = 32'hA5A50F0F; wstrb[k] = 4'hF; bready[k] = 1'b1;
    awvalid[k] = 1'b1; wvalid[k] = 1'b1;
    n = 0;
    while (!awready[k] && n < 64) begin @(negedge clock); n++; end
    @(negedge clock);
    awvalid[k] = 1'b0; wvalid[k] = 1'b0;
    check("rst_wr_strobe_seen", 32'(csr_vld[k]), 32'd1);
    rst_n[k] = 1'b0;
    #1;
    check("rst_wr_strobe_drop", {30'd0, csr_vld[k], csr_we[k]}, 32'd0);
    repeat (2) @(negedge clock);
    rst_n[k] = 1'b1;
    @(negedge clock);
    read_txn(k, 12'h03C, 0);
    read_txn(k, 12'h010, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < N; k++) begin
      rst_n[k] = 1'b0;
      awaddr[k] = '0; awvalid[k] = 1'b0; wdata[k] = '0; wstrb[k] = '0; wvalid[k] = 1'b0;
      araddr[k] = '0; arvalid[k] = 1'b0; bready[k] = 1'b1; rready[k] = 1'b1;
    end
    repeat (3) @(negedge clock);
    for (int k = 0; k < N; k++) begin
      check("reset_ctrl", {25'd0, awready[k], wready[k], arready[k], bvalid[k], rvalid[k], csr_vld[k], csr_we[k]}, 32'd0);
      check("reset_csr_addr", 32'(csr_addr[k]), 32'd0);
      check("reset_csr_wdata", csr_wdat[k], 32'd0);
      check("reset_rdata", rdata[k], 32'd0);
      check("reset_resp", {28'd0, bresp[k], rresp[k]}, 32'd0);
      rst_n[k] = 1'b1;
    end
    @(negedge clock);

    for (int k = 0; k < N; k++) arb_test(k);

    for (int k = 0; k < N; k++) begin
      read_txn(k, 12'h010, 0);
      write_txn(k, 12'h010, 32'hDEADBEEF, 4'hF, 0, 1'b0);
      read_txn(k, 12'h013, 0);
      read_txn(k, 12'h400, 0);
      write_txn(k, 12'h010, 32'h0BAD0BAD, 4'h3, 0, 1'b0);
      write_txn(k, 12'h800, 32'h11112222, 4'hF, 0, 1'b0);
      read_txn(k, 12'h010, 2);
    end

    // response stall with a competing read presented during the stall
    araddr[0] = 12'h014;
    write_txn(0, 12'h018, 32'hCAFEF00D, 4'hF, 10, 1'b1);
    read_txn(0, 12'h014, 0);
    read_txn(0, 12'h018, 0);

    reset_mid_test(2);

    for (int k = 0; k < N; k++) begin
      for (int i = 0; i < 30; i++) begin
        logic [11:0] a;
        logic [3:0]  s;
        int          dly;
        a = {2'b00, 8'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
        if ($urandom_range(0, 7) == 0) a[11:10] = 2'($urandom_range(1, 3));
        dly = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
        if ($urandom_range(0, 1) == 1) begin
          s = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 14)) : 4'hF;
          write_txn(k, a, $urandom, s, dly, 1'b0);
        end else begin
          read_txn(k, a, dly);
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
